conv_line_feeder: RTL

Raster-to-column feeder for the 3×3 convolution engine. It accepts a row-major pixel stream one pixel per handshake and buffers the previous two image rows. For each column it emits a vertically aligned triple (top/mid/bot) with a shift strobe, a per-row clear pulse, and a window-valid flag. It replaces bench-side row indexing: it sits between the pixel source and `conv33`, and drives that engine's `pix_top`, `pix_mid`, `pix_bot`, `shift_en` and row-clear inputs.

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_line_feeder_line_buf.sv | 24 ++
 rtl/conv_line_feeder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv33 feeder and its benches.
// Frame geometry default and the feeder FSM encoding live here.
package conv_pkg;

  localparam int IMG_W_DEF   = 252;
  localparam int PIXEL_W_DEF = 8;

  typedef logic [PIXEL_W_DEF-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    CLR,
    DONE
  } feed_state_t;

endpackage

// File: rtl/conv_line_feeder_line_buf.sv
// One image row of storage, indexed by column.
// Read returns the old word while a write lands at the same address.
module line_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 252,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // write-only port; the combinational read sees pre-edge contents
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_line_feeder.sv
// Raster-to-column feeder for the 3x3 convolution engine.
// Optional mid-frame resync on in_sof: define CONV_FEED_SOF_RESYNC_EN.
module conv_line_feeder
  import conv_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_W_DEF,
  parameter int IMG_W       = IMG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic                   col_shift,
  output logic                   row_clr,
  output logic                   win_valid,
  output logic                   frame_done,
  output logic                   sof_err
);

  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  feed_state_t state;
  feed_state_t nxt;

  logic [CW-1:0] col;
  logic [CW-1:0] row;

  logic xfer;
  logic start;
  logic resync;
  logic restart;
  logic fill_x;
  logic strm_x;
  logic lb_we;
  logic [CW-1:0] lb_addr;

  logic [PIXEL_WIDTH-1:0] lb0_rd;
  logic [PIXEL_WIDTH-1:0] lb1_rd;

  logic ready_d;
  logic clr_d;
  logic done_d;

  assign xfer  = in_valid && in_ready;
  assign start = xfer && in_sof && (state == IDLE);

`ifdef CONV_FEED_SOF_RESYNC_EN
  assign resync = xfer && in_sof &&
                  ((state == FILL) || (state == STREAM));
`else
  assign resync = 1'b0;
`endif

  // a restart pixel is always column 0 of row 0
  assign restart = start || resync;
  assign fill_x  = xfer && (state == FILL) && !resync;
  assign strm_x  = xfer && (state == STREAM) && !resync;
  assign lb_we   = restart || fill_x || strm_x;
  assign lb_addr = restart ? '0 : col;

  // LB0 holds row r-1, LB1 holds row r-2
  line_buf #(
    .WIDTH (PIXEL_WIDTH),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb0 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (in_pixel),
    .rdata (lb0_rd)
  );

  line_buf #(
    .WIDTH (PIXEL_WIDTH),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb1 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = FILL;
      end
      FILL: begin
        if (resync) nxt = FILL;
        else if (fill_x && col == LAST && row == ONE)
          nxt = STREAM;
      end
      STREAM: begin
        if (resync) nxt = FILL;
        else if (strm_x && col == LAST) nxt = CLR;
      end
      CLR: begin
        nxt = (row == LAST) ? DONE : STREAM;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // output decode, registered below so ready carries no comb path
  always_comb begin
    ready_d = (nxt == IDLE) || (nxt == FILL) ||
              (nxt == STREAM);
    clr_d   = (state == CLR);
    done_d  = (state == DONE);
  end

  // column/row position of the next pixel to arrive
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (restart) begin
      col <= ONE;
      row <= '0;
    end else if (fill_x || strm_x) begin
      if (col == LAST) begin
        col <= '0;
        if (fill_x) row <= row + ONE;
      end else begin
        col <= col + ONE;
      end
    end else if (state == CLR) begin
      if (row != LAST) row <= row + ONE;
    end else if (state == DONE) begin
      row <= '0;
    end
  end

  // registered engine-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b0;
      col_shift  <= 1'b0;
      win_valid  <= 1'b0;
      row_clr    <= 1'b0;
      frame_done <= 1'b0;
      pix_top    <= '0;
      pix_mid    <= '0;
      pix_bot    <= '0;
    end else begin
      in_ready   <= ready_d;
      col_shift  <= strm_x;
      win_valid  <= strm_x && (col >= TWO);
      row_clr    <= clr_d;
      frame_done <= done_d;
      if (strm_x) begin
        pix_top <= lb1_rd;
        pix_mid <= lb0_rd;
        pix_bot <= in_pixel;
      end
    end
  end

`ifdef CONV_FEED_SOF_RESYNC_EN
  // flag the unexpected start-of-frame that forced the restart
  always_ff @(posedge clk) begin
    if (rst) sof_err <= 1'b0;
    else     sof_err <= resync;
  end
`else
  assign sof_err = 1'b0;
`endif

endmodule
